// File: rtl/painterengine_gpu_dvi_capture.sv
// Parallel video capture: samples HS/VS/DE/RGB24, locks to a frame on the VS active edge,
// crops to a clip window and repacks each kept pixel into 32-bit RGBA.
module painterengine_gpu_dvi_capture #(
    parameter logic [7:0] PARAM_ALPHA = 8'hFF
) (
    input  logic        i_wire_pixel_clock,
    input  logic        i_wire_resetn,
    input  logic        i_wire_start,
    input  logic        i_wire_hs,
    input  logic        i_wire_vs,
    input  logic        i_wire_de,
    input  logic [23:0] i_wire_rgb,
    input  logic        i_wire_hs_pol,
    input  logic        i_wire_vs_pol,
    input  logic [2:0]  i_wire_rgba_mode,
    input  logic [15:0] i_wire_clip_width,
    input  logic [15:0] i_wire_clip_height,
    output logic [31:0] o_wire_rgba,
    output logic        o_wire_rgba_valid,
    output logic        o_wire_busy,
    output logic        o_wire_done,
    output logic        o_wire_short_frame,
    output logic [15:0] o_wire_meas_width,
    output logic [15:0] o_wire_lines
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitVs  = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } state_e;

    // Input stage registers
    logic        s1_hs_q, s1_vs_q, s1_de_q;
    logic [23:0] s1_rgb_q;
    logic        vs_act_dly_q, vs_act_dly_d;
    logic        s1_de_dly_q, s1_de_dly_d;

    // Position counters
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;

    // FSM and status
    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        short_q, short_d;
    logic [15:0] meas_q, meas_d;
    logic        meas_seen_q, meas_seen_d;
    logic [15:0] lines_q, lines_d;
    logic [31:0] count_q, count_d;

    // Pixel output
    logic [31:0] rgba_q, rgba_d;
    logic        valid_q, valid_d;

    logic        vs_act, vs_edge, de_fall, keep;
    logic [31:0] target;

    // HS is registered for completeness but framing is DE-based.
    logic        unused_hs;
    assign unused_hs = s1_hs_q ^ i_wire_hs_pol;

    assign vs_act  = (s1_vs_q == i_wire_vs_pol);
    assign vs_edge = vs_act & ~vs_act_dly_q;
    assign de_fall = ~s1_de_q & s1_de_dly_q;
    assign target  = 32'(i_wire_clip_width) * 32'(i_wire_clip_height);
    assign keep    = (state_q == StCapture) && s1_de_q &&
                     (x_q < i_wire_clip_width) && (y_q < i_wire_clip_height);

    function automatic logic [31:0] pack_pixel(input logic [23:0] rgb, input logic [2:0] mode);
        logic [7:0]  r, g, b;
        logic [31:0] res;
        r = rgb[23:16];
        g = rgb[15:8];
        b = rgb[7:0];
        case (mode)
            3'd0:    res = {PARAM_ALPHA, r, g, b};
            3'd1:    res = {r, g, b, PARAM_ALPHA};
            3'd2:    res = {PARAM_ALPHA, b, g, r};
            3'd3:    res = {b, g, r, PARAM_ALPHA};
            default: res = 32'h0;
        endcase
        return res;
    endfunction

    // Input stage: register raw video every cycle
    always_ff @(posedge i_wire_pixel_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            s1_hs_q      <= 1'b0;
            s1_vs_q      <= 1'b0;
            s1_de_q      <= 1'b0;
            s1_rgb_q     <= 24'h0;
            vs_act_dly_q <= 1'b0;
            s1_de_dly_q  <= 1'b0;
        end else begin
            s1_hs_q      <= i_wire_hs;
            s1_vs_q      <= i_wire_vs;
            s1_de_q      <= i_wire_de;
            s1_rgb_q     <= i_wire_rgb;
            vs_act_dly_q <= vs_act_dly_d;
            s1_de_dly_q  <= s1_de_dly_d;
        end
    end

    // Next-state for pixel/line position; both counters saturate
    always_comb begin
        vs_act_dly_d = vs_act;
        s1_de_dly_d  = s1_de_q;
        x_d          = 16'h0;
        if (s1_de_q) begin
            x_d = (x_q == 16'hFFFF) ? x_q : x_q + 16'd1;
        end
        y_d = y_q;
        if (vs_edge) begin
            y_d = 16'h0;
        end else if (de_fall && (y_q != 16'hFFFF)) begin
            y_d = y_q + 16'd1;
        end
    end

    // Position counter registers
    always_ff @(posedge i_wire_pixel_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            x_q <= 16'h0;
            y_q <= 16'h0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // FSM next-state and status updates
    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        short_d     = short_q;
        meas_d      = meas_q;
        meas_seen_d = meas_seen_q;
        lines_d     = lines_q;
        count_d     = count_q;
        case (state_q)
            StIdle, StDone: begin
                if (i_wire_start) begin
                    state_d     = StWaitVs;
                    done_d      = 1'b0;
                    short_d     = 1'b0;
                    meas_d      = 16'h0;
                    meas_seen_d = 1'b0;
                    lines_d     = 16'h0;
                    count_d     = 32'h0;
                end
            end
            StWaitVs: begin
                if (vs_edge) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (keep) begin
                    count_d = count_q + 32'd1;
                end
                if (de_fall && !meas_seen_q) begin
                    meas_d      = x_q;
                    meas_seen_d = 1'b1;
                end
                // Fill check takes priority: a full window is never a short frame.
                if (count_q == target) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    lines_d = y_q;
                end else if (vs_edge) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    short_d = 1'b1;
                    lines_d = y_q;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StWaitVs) || (state_d == StCapture);
    end

    // FSM state and registered status outputs
    always_ff @(posedge i_wire_pixel_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            meas_q      <= 16'h0;
            meas_seen_q <= 1'b0;
            lines_q     <= 16'h0;
            count_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            short_q     <= short_d;
            meas_q      <= meas_d;
            meas_seen_q <= meas_seen_d;
            lines_q     <= lines_d;
            count_q     <= count_d;
        end
    end

    // Pack kept pixels; hold the last packed value between strobes
    always_comb begin
        valid_d = keep;
        rgba_d  = rgba_q;
        if (keep) begin
            rgba_d = pack_pixel(s1_rgb_q, i_wire_rgba_mode);
        end
    end

    // Pixel output registers
    always_ff @(posedge i_wire_pixel_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            rgba_q  <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            rgba_q  <= rgba_d;
            valid_q <= valid_d;
        end
    end

    assign o_wire_rgba        = rgba_q;
    assign o_wire_rgba_valid  = valid_q;
    assign o_wire_busy        = busy_q;
    assign o_wire_done        = done_q;
    assign o_wire_short_frame = short_q;
    assign o_wire_meas_width  = meas_q;
    assign o_wire_lines       = lines_q;

endmodule

// File: tb/tb_painterengine_gpu_dvi_capture.sv
// Directed bench for the DVI capture block using scaled-down frame geometry
// (40x6 active in 50x12 total; short source 24x4 in 30x8).
module tb_painterengine_gpu_dvi_capture;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start, hs, vs, de;
    logic [23:0] rgb;
    logic        hs_pol, vs_pol;
    logic [2:0]  mode;
    logic [15:0] cw, ch;
    logic [31:0] rgba;
    logic        valid, busy, done, short_frame;
    logic [15:0] meas, lines;

    painterengine_gpu_dvi_capture #(.PARAM_ALPHA(8'hFF)) dut (
        .i_wire_pixel_clock (clk),
        .i_wire_resetn      (rstn),
        .i_wire_start       (start),
        .i_wire_hs          (hs),
        .i_wire_vs          (vs),
        .i_wire_de          (de),
        .i_wire_rgb         (rgb),
        .i_wire_hs_pol      (hs_pol),
        .i_wire_vs_pol      (vs_pol),
        .i_wire_rgba_mode   (mode),
        .i_wire_clip_width  (cw),
        .i_wire_clip_height (ch),
        .o_wire_rgba        (rgba),
        .o_wire_rgba_valid  (valid),
        .o_wire_busy        (busy),
        .o_wire_done        (done),
        .o_wire_short_frame (short_frame),
        .o_wire_meas_width  (meas),
        .o_wire_lines       (lines)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned checks = 0;
    int unsigned failures = 0;

    // Monitor state (written only by the monitor process)
    int unsigned n_strobe = 0, n_bad = 0;
    int unsigned first_strobe_cyc = 0, last_strobe_cyc = 0, done_rise_cyc = 0;
    logic [31:0] first_rgba = 32'h0, last_rgba = 32'h0;
    logic        done_prev = 1'b0;
    // Monitor controls (written only by the stimulus process)
    int unsigned mark = 0, bad_mark = 0;
    logic        chk_const = 1'b0;
    logic [31:0] exp_rgba = 32'h0;
    // Driver timestamps
    int unsigned first_de_cyc = 0, vs_start_cyc = 0;

    always @(negedge clk) begin
        if (valid) begin
            if (n_strobe == mark) begin
                first_rgba       = rgba;
                first_strobe_cyc = cyc;
            end
            last_rgba       = rgba;
            last_strobe_cyc = cyc;
            if (chk_const && (rgba !== exp_rgba)) n_bad++;
            n_strobe++;
        end
        if (done && !done_prev) done_rise_cyc = cyc;
        done_prev = done;
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic arm();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // One frame: 2 VS lines, 2 back-porch lines, v_act active lines, rest front porch.
    task automatic gen_frame(input int h_act, input int h_tot, input int v_act, input int v_tot,
                             input bit ramp, input logic [23:0] cval, input int start_line);
        bit seen;
        seen = 1'b0;
        for (int l = 0; l < v_tot; l++) begin
            for (int p = 0; p < h_tot; p++) begin
                @(posedge clk);
                #1;
                start = (l == start_line) && (p == 5);
                vs    = (l < 2) ? vs_pol : ~vs_pol;
                hs    = (p >= h_tot - 5 && p < h_tot - 2) ? hs_pol : ~hs_pol;
                de    = (l >= 4) && (l < 4 + v_act) && (p < h_act);
                rgb   = de ? (ramp ? {8'h00, 8'(l - 4), 8'(p)} : cval) : 24'h0;
                if (l == 0 && p == 0) vs_start_cyc = cyc;
                if (de && !seen) begin
                    first_de_cyc = cyc;
                    seen = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; start = 1'b0; hs = 1'b0; vs = 1'b1; de = 1'b0; rgb = 24'h0;
        hs_pol = 1'b1; vs_pol = 1'b0; mode = 3'd0; cw = 16'd40; ch = 16'd6;

        // Reset state
        idle(3); #1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_rgba", rgba, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_meas", 32'(meas), 32'd0);
        chk("rst_lines", 32'(lines), 32'd0);
        @(posedge clk); #1 rstn = 1'b1;
        idle(4);

        // Test 1: full-frame capture, ARGB, ramp data
        mark = n_strobe;
        arm();
        #1 chk("t1_busy_armed", 32'(busy), 32'd1);
        gen_frame(40, 50, 6, 12, 1'b1, 24'h0, -1);
        idle(3); #1;
        chk("t1_strobes", n_strobe - mark, 32'd240);
        chk("t1_first_rgba", first_rgba, 32'hFF000000);
        chk("t1_last_rgba", last_rgba, 32'hFF000527);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_short", 32'(short_frame), 32'd0);
        chk("t1_meas", 32'(meas), 32'd40);
        chk("t1_lines", 32'(lines), 32'd5);

        // Test 2: clip 10x2, RGBA, constant colour
        cw = 16'd10; ch = 16'd2; mode = 3'd1;
        exp_rgba = 32'h123456FF; chk_const = 1'b1;
        mark = n_strobe; bad_mark = n_bad;
        arm();
        gen_frame(40, 50, 6, 12, 1'b0, 24'h123456, -1);
        idle(3); #1;
        chk_const = 1'b0;
        chk("t2_strobes", n_strobe - mark, 32'd20);
        chk("t2_bad_pixels", n_bad - bad_mark, 32'd0);
        chk("t2_done_latency", done_rise_cyc - last_strobe_cyc, 32'd1);
        chk("t2_rgba_hold", rgba, 32'h123456FF);
        chk("t2_lines", 32'(lines), 32'd1);
        chk("t2_meas", 32'(meas), 32'd40);

        // Test 3: arm mid-frame (VS inactive); capture starts on next frame
        cw = 16'd40; ch = 16'd6; mode = 3'd0;
        mark = n_strobe;
        gen_frame(40, 50, 6, 12, 1'b1, 24'h0, 6);
        chk("t3_no_strobe_before_vs", n_strobe - mark, 32'd0);
        chk("t3_busy_waiting", 32'(busy), 32'd1);
        gen_frame(40, 50, 6, 12, 1'b1, 24'h0, -1);
        idle(3); #1;
        chk("t3_first_latency", first_strobe_cyc - first_de_cyc, 32'd2);
        chk("t3_first_rgba", first_rgba, 32'hFF000000);
        chk("t3_strobes", n_strobe - mark, 32'd240);
        chk("t3_done", 32'(done), 32'd1);

        // Test 4: 24x4 source into 40x6 clip ends short on the next VS edge
        mark = n_strobe;
        arm();
        gen_frame(24, 30, 4, 8, 1'b1, 24'h0, -1);
        #1 chk("t4_not_done_yet", 32'(done), 32'd0);
        gen_frame(24, 30, 4, 8, 1'b1, 24'h0, -1);
        idle(2); #1;
        chk("t4_strobes", n_strobe - mark, 32'd96);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_short", 32'(short_frame), 32'd1);
        chk("t4_meas", 32'(meas), 32'd24);
        chk("t4_lines", 32'(lines), 32'd4);

        // Test 5a: zero-width clip finishes right after the VS edge
        cw = 16'd0; ch = 16'd6;
        mark = n_strobe;
        arm();
        gen_frame(40, 50, 6, 12, 1'b1, 24'h0, -1);
        idle(2); #1;
        chk("t5_zero_strobes", n_strobe - mark, 32'd0);
        chk("t5_zero_done", 32'(done), 32'd1);
        chk("t5_zero_short", 32'(short_frame), 32'd0);
        chk("t5_zero_done_cyc", done_rise_cyc - vs_start_cyc, 32'd3);

        // Test 5b: asynchronous reset during capture
        cw = 16'd40; ch = 16'd6;
        arm();
        fork
            gen_frame(40, 50, 6, 12, 1'b1, 24'h0, -1);
            begin
                idle(300);
                #2;
                chk("t5_busy_pre_reset", 32'(busy), 32'd1);
                rstn = 1'b0;
                #1;
                chk("t5_rst_valid", 32'(valid), 32'd0);
                chk("t5_rst_rgba", rgba, 32'h0);
                chk("t5_rst_busy", 32'(busy), 32'd0);
                chk("t5_rst_done", 32'(done), 32'd0);
                chk("t5_rst_meas", 32'(meas), 32'd0);
                idle(3);
                #2 rstn = 1'b1;
            end
        join
        mark = n_strobe;
        gen_frame(40, 50, 6, 12, 1'b1, 24'h0, -1);
        #1;
        chk("t5_no_strobe_unarmed", n_strobe - mark, 32'd0);
        chk("t5_idle_busy", 32'(busy), 32'd0);
        arm();
        gen_frame(40, 50, 6, 12, 1'b1, 24'h0, -1);
        idle(2); #1;
        chk("t5_rearm_strobes", n_strobe - mark, 32'd240);
        chk("t5_rearm_done", 32'(done), 32'd1);

        // Test 6a: reserved mode packs to zero
        cw = 16'd4; ch = 16'd1; mode = 3'b101;
        exp_rgba = 32'h0; chk_const = 1'b1;
        mark = n_strobe; bad_mark = n_bad;
        arm();
        gen_frame(40, 50, 6, 12, 1'b0, 24'hAABBCC, -1);
        idle(2); #1;
        chk("t6_rsv_strobes", n_strobe - mark, 32'd4);
        chk("t6_rsv_bad", n_bad - bad_mark, 32'd0);
        chk("t6_rsv_rgba", rgba, 32'h0);

        // Test 6b: ABGR packing
        mode = 3'd2; exp_rgba = 32'hFFCCBBAA;
        mark = n_strobe; bad_mark = n_bad;
        arm();
        gen_frame(40, 50, 6, 12, 1'b0, 24'hAABBCC, -1);
        idle(2); #1;
        chk_const = 1'b0;
        chk("t6_abgr_strobes", n_strobe - mark, 32'd4);
        chk("t6_abgr_bad", n_bad - bad_mark, 32'd0);
        chk("t6_abgr_rgba", rgba, 32'hFFCCBBAA);
        chk("t6_abgr_done", 32'(done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
